// File: rtl/fp_mul_pkg.sv
// Shared constants, operand classes and the exponent bias helper for the
// pipelined floating-point multiplier.
package fp_mul_pkg;

  localparam int EXP_W_DEF      = 8;
  localparam int MAN_W_DEF      = 23;
  localparam int FLAG_W         = 3;
  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } op_class_e;

  function automatic int fp_bias(input int exp_w);
    return (32'sd1 << (exp_w - 1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Rounds a normalised significand (leading one at the MSB) to MAN_W fraction bits.
// FP_MUL_RNE_EN selects round-to-nearest-even; otherwise the fraction is truncated.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [2*MAN_W+1:0] sig,
  output logic [MAN_W-1:0]   frac,
  output logic               exp_inc
);

`ifdef FP_MUL_RNE_EN
  logic           guard;
  logic           round_bit;
  logic           sticky;
  logic           round_up;
  logic [MAN_W:0] sum;
  logic           unused_bits;

  assign unused_bits = sig[2*MAN_W+1];

  // Guard/round/sticky decision; an all-ones fraction carrying out bumps the exponent.
  always_comb begin
    guard     = sig[MAN_W];
    round_bit = sig[MAN_W-1];
    sticky    = |sig[MAN_W-2:0];
    round_up  = guard & (round_bit | sticky | sig[MAN_W+1]);
    sum       = {1'b0, sig[2*MAN_W:MAN_W+1]} + {{MAN_W{1'b0}}, round_up};
    frac      = sum[MAN_W-1:0];
    exp_inc   = sum[MAN_W];
  end
`else
  logic unused_bits;

  assign unused_bits = ^{sig[2*MAN_W+1], sig[MAN_W:0]};

  // Round toward zero: keep the top fraction bits and drop the rest.
  always_comb begin
    frac    = sig[2*MAN_W:MAN_W+1];
    exp_inc = 1'b0;
  end
`endif

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// Define FP_MUL_RNE_EN for round-to-nearest-even; default build truncates.
module fp_multiplier_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [FLAG_W-1:0]      flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS_S     = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EXP_MAX_S  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0] EXP_ZERO_S = {EW{1'b0}};

  logic                 advance;
  op_class_e            cls_a, cls_b, s1_cls_d, s1_cls, s2_cls;
  logic signed [EW-1:0] s1_exp_d, s1_exp, s2_exp, exp_fin;
  logic                 s1_valid, s1_sign, s2_valid, s2_sign;
  logic [MAN_W:0]       s1_man_a, s1_man_b;
  logic [PW-1:0]        s2_prod, norm;
  logic                 prod_msb, exp_inc;
  logic [MAN_W-1:0]     frac_rnd;
  logic [W-1:0]         result_d;
  logic [FLAG_W-1:0]    flags_d;

  function automatic op_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    op_class_e c;
    if (e == {EXP_W{1'b0}})      c = ZERO;
    else if (e != {EXP_W{1'b1}}) c = NORMAL;
    else if (f == {MAN_W{1'b0}}) c = INF;
    else                         c = NAN;
    return c;
  endfunction

  // The whole pipeline freezes only while a finished result waits on the consumer.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // S1: classify operands, resolve special cases, sum biased exponents.
  always_comb begin
    cls_a = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
    cls_b = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    if (cls_a == NAN || cls_b == NAN || (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF))
      s1_cls_d = NAN;
    else if (cls_a == INF || cls_b == INF)
      s1_cls_d = INF;
    else if (cls_a == ZERO || cls_b == ZERO)
      s1_cls_d = ZERO;
    else
      s1_cls_d = NORMAL;
    s1_exp_d = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - BIAS_S;
  end

  // Stage registers S1 and S2; bubbles flow through with their valid bit low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_cls   <= ZERO;
      s1_exp   <= EXP_ZERO_S;
      s1_man_a <= {(MAN_W+1){1'b0}};
      s1_man_b <= {(MAN_W+1){1'b0}};
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_cls   <= ZERO;
      s2_exp   <= EXP_ZERO_S;
      s2_prod  <= {PW{1'b0}};
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sign  <= a[W-1] ^ b[W-1];
      s1_cls   <= s1_cls_d;
      s1_exp   <= s1_exp_d;
      s1_man_a <= {1'b1, a[MAN_W-1:0]};
      s1_man_b <= {1'b1, b[MAN_W-1:0]};
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_cls   <= s1_cls;
      s2_exp   <= s1_exp;
      s2_prod  <= {{(MAN_W+1){1'b0}}, s1_man_a} * {{(MAN_W+1){1'b0}}, s1_man_b};
    end else begin
      s1_valid <= s1_valid;
      s2_valid <= s2_valid;
    end
  end

  assign prod_msb = s2_prod[PW-1];
  assign norm     = prod_msb ? s2_prod : {s2_prod[PW-2:0], 1'b0};

  fp_mul_round #(.MAN_W(MAN_W)) u_round (
    .sig     (norm),
    .frac    (frac_rnd),
    .exp_inc (exp_inc)
  );

  // S3: exponent after normalise and rounding carry, then range check and pack.
  always_comb begin
    exp_fin  = s2_exp + $signed({{(EW-1){1'b0}}, prod_msb}) + $signed({{(EW-1){1'b0}}, exp_inc});
    result_d = {W{1'b0}};
    flags_d  = {FLAG_W{1'b0}};
    case (s2_cls)
      NAN: begin
        result_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_d[FLAG_INVALID] = 1'b1;
      end
      INF:  result_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ZERO: result_d = {s2_sign, {(W-1){1'b0}}};
      NORMAL: begin
        if (exp_fin >= EXP_MAX_S) begin
          result_d = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d[FLAG_OVERFLOW] = 1'b1;
        end else if (exp_fin <= EXP_ZERO_S) begin
          result_d = {s2_sign, {(W-1){1'b0}}};
          flags_d[FLAG_UNDERFLOW] = 1'b1;
        end else begin
          result_d = {s2_sign, exp_fin[EXP_W-1:0], frac_rnd};
        end
      end
      default: begin
        result_d = {W{1'b0}};
        flags_d  = {FLAG_W{1'b0}};
      end
    endcase
  end

  // Output register: holds result and flags steady while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= {W{1'b0}};
      flags     <= {FLAG_W{1'b0}};
    end else if (advance) begin
      out_valid <= s2_valid;
      result    <= result_d;
      flags     <= flags_d;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Randomised self-checking bench for fp_multiplier_pipe (single precision),
// scored against a field-level arithmetic reference model.
module tb_fp_multiplier_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_out = 0;
  bit lat_mode = 1'b0;
  bit held_v = 1'b0;
  logic [34:0] held_val;
  logic [34:0] exp_q[$];
  int          acc_q[$];

  fp_multiplier_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: exact integer product of significands, rounded by remainder comparison.
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    bit s, zx, zy, ix, iy, nx, ny;
    longint unsigned mx, my, prod, q;
`ifdef FP_MUL_RNE_EN
    longint unsigned rem, half;
`endif
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    nx = (ex == 255) && (x[22:0] != 23'h0);
    ny = (ey == 255) && (y[22:0] != 23'h0);
    ix = (ex == 255) && (x[22:0] == 23'h0);
    iy = (ey == 255) && (y[22:0] == 23'h0);
    zx = (ex == 0);
    zy = (ey == 0);
    s  = x[31] ^ y[31];
    if (nx || ny || (ix && zy) || (zx && iy)) return {3'b100, 32'h7FC00000};
    if (ix || iy) return {3'b000, s, 8'hFF, 23'h0};
    if (zx || zy) return {3'b000, s, 31'h0};
    mx = 64'(x[22:0]) + (64'd1 << 23);
    my = 64'(y[22:0]) + (64'd1 << 23);
    prod = mx * my;
    e  = ex + ey - 127;
    sh = 23;
    if (prod >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end
    q = prod >> sh;
`ifdef FP_MUL_RNE_EN
    rem  = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
`endif
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b001, s, 31'h0};
    return {3'b000, s, 8'(e), 23'(q)};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int sel;
    v = $urandom;
    sel = $urandom_range(9);
    case (sel)
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      3, 4, 5, 6: v[30:23] = 8'($urandom_range(190, 64));
      default: ;
    endcase
    return v;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 time unit later.
  task automatic step(input bit iv, input logic [31:0] av, input logic [31:0] bv,
                      input bit ordy, input logic [34:0] expv, output bit acc);
    int lat;
    @(negedge clk);
    in_valid = iv; a = av; b = bv; out_ready = ordy;
    #1;
    check("in_ready", {34'd0, in_ready}, {34'd0, !(out_valid && !out_ready)});
    if (held_v) begin
      check("hold_valid", {34'd0, out_valid}, 35'd1);
      check("hold_data", {flags, result}, held_val);
    end
    held_v = 1'b0;
    if (out_valid) begin
      if (!out_ready) begin
        held_v = 1'b1;
        held_val = {flags, result};
      end else if (exp_q.size() == 0) begin
        check("spurious_out", {34'd0, out_valid}, 35'd0);
      end else begin
        check("result", {flags, result}, exp_q.pop_front());
        lat = cyc - acc_q.pop_front();
        n_out++;
        if (lat_mode) check("latency", 35'(lat), 35'd3);
      end
    end
    acc = iv && in_ready;
    if (acc) begin
      exp_q.push_back(expv);
      acc_q.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++)
      step(1'b0, 32'h0, 32'h0, 1'b1, 35'h0, acc);
    check("drain_empty", 35'(exp_q.size()), 35'd0);
  endtask

  logic [31:0] da [10];
  logic [31:0] db [10];
  logic [34:0] dexp [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    logic [31:0] ra, rb;
    logic [31:0] sa [8];
    logic [31:0] sb [8];
    int k, n0;

    da[0] = 32'h3FC00000; db[0] = 32'h40000000; dexp[0] = {3'b000, 32'h40400000};
    da[1] = 32'h3F800001; db[1] = 32'h3FC00000;
`ifdef FP_MUL_RNE_EN
    dexp[1] = {3'b000, 32'h3FC00002};
`else
    dexp[1] = {3'b000, 32'h3FC00001};
`endif
    da[2] = 32'h7F000000; db[2] = 32'h7F000000; dexp[2] = {3'b010, 32'h7F800000};
    da[3] = 32'h00800000; db[3] = 32'h00800000; dexp[3] = {3'b001, 32'h00000000};
    da[4] = 32'h7F800000; db[4] = 32'h00000000; dexp[4] = {3'b100, 32'h7FC00000};
    da[5] = 32'hFF800000; db[5] = 32'h40000000; dexp[5] = {3'b000, 32'hFF800000};
    da[6] = 32'h7FC00001; db[6] = 32'h3F800000; dexp[6] = {3'b100, 32'h7FC00000};
    da[7] = 32'h00000000; db[7] = 32'hC0000000; dexp[7] = {3'b000, 32'h80000000};
    da[8] = 32'h00000001; db[8] = 32'h3F800000; dexp[8] = {3'b000, 32'h00000000};
    da[9] = 32'hC0400000; db[9] = 32'h40800000; dexp[9] = {3'b000, 32'hC1400000};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", {34'd0, out_valid}, 35'd0);
    check("rst_result", {3'b000, result}, 35'd0);
    check("rst_flags", {32'd0, flags}, 35'd0);
    check("rst_in_ready", {34'd0, in_ready}, 35'd1);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Directed vectors back to back, first one on the first edge after release
    lat_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, da[i], db[i], 1'b1, dexp[i], acc);
      check("directed_accept", {34'd0, acc}, 35'd1);
    end
    drain();
    lat_mode = 1'b0;

    // Randomised traffic with random bubbles and back-pressure
    ra = rand_op();
    rb = rand_op();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), ra, rb, ($urandom_range(4) != 0), ref_mul(ra, rb), acc);
      if (acc) begin
        ra = rand_op();
        rb = rand_op();
      end
    end
    drain();

    // Eight-operand stream with a four-cycle consumer stall mid-stream
    for (int i = 0; i < 8; i++) begin
      sa[i] = rand_op();
      sb[i] = rand_op();
    end
    k = 0;
    n0 = n_out;
    for (int i = 0; i < 40 && (k < 8 || exp_q.size() != 0); i++) begin
      if (k < 8) step(1'b1, sa[k], sb[k], !(i >= 3 && i < 7), ref_mul(sa[k], sb[k]), acc);
      else step(1'b0, 32'h0, 32'h0, 1'b1, 35'h0, acc);
      if (i >= 4 && i < 7) check("stall_in_ready", {34'd0, in_ready}, 35'd0);
      if (acc) k++;
    end
    check("stream_count", 35'(n_out - n0), 35'd8);

    // Reset with three operations in flight
    lat_mode = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, da[i], db[i], 1'b1, dexp[i], acc);
    @(posedge clk);
    #2;
    check("pre_rst_valid", {34'd0, out_valid}, 35'd1);
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", {34'd0, out_valid}, 35'd0);
    check("midrst_result", {flags, result}, 35'd0);
    check("midrst_in_ready", {34'd0, in_ready}, 35'd1);
    exp_q.delete();
    acc_q.delete();
    held_v = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 35'h0, acc);
    step(1'b1, da[9], db[9], 1'b1, dexp[9], acc);
    check("post_rst_accept", {34'd0, acc}, 35'd1);
    n0 = n_out;
    drain();
    check("post_rst_count", 35'(n_out - n0), 35'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
